// File: rtl/beep_driver.sv
// Purpose : turns a one-cycle start request into 0..2^NW-1 timed buzzer pulses (ON_CYC high, OFF_CYC low).
// Latency : buzz rises the cycle after start is accepted; done pulses n*ON_CYC+(n-1)*OFF_CYC+1 cycles after acceptance.
// Backpress: start is honoured only while ready=1; requests arriving while busy are dropped, not queued.
//
// Ports:
//   clk, rst_n   rising-edge clock, synchronous active-low reset
//   start/beeps  request strobe and beep count (beeps sampled only on an accepted start)
//   stop         abort of the running pattern (also vetoes a simultaneous start)
//   ready/busy   idle / pattern-in-progress, decoded from state
//   buzz         registered buzzer drive
//   done         registered one-cycle end-of-pattern pulse (completed or aborted)
module beep_driver #(
    parameter int ON_CYC  = 10,
    parameter int OFF_CYC = 10,
    parameter int CW      = 4,
    parameter int NW      = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [NW-1:0] beeps,
    input  logic          stop,
    output logic          ready,
    output logic          busy,
    output logic          buzz,
    output logic          done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ON   = 2'd1,
        S_GAP  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Timers count down to zero inclusive, so a phase of N cycles loads N-1.
    // This lets a full 2^CW-cycle phase fit in a CW-bit timer.
    localparam logic [CW-1:0] ON_LOAD  = CW'(ON_CYC - 1);
    localparam logic [CW-1:0] OFF_LOAD = CW'(OFF_CYC - 1);

    state_t        state;
    logic [CW-1:0] timer;
    logic [NW-1:0] remaining;

    assign ready = (state == S_IDLE);
    assign busy  = ~ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            timer     <= '0;
            remaining <= '0;
            buzz      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    buzz <= 1'b0;
                    done <= 1'b0;
                    // stop wins over a simultaneous start: the request is dropped
                    if (start && !stop) begin
                        remaining <= beeps;
                        if (beeps == '0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= S_ON;
                            timer <= ON_LOAD;
                            buzz  <= 1'b1;
                        end
                    end
                end

                S_ON: begin
                    if (stop) begin
                        state <= S_DONE;
                        buzz  <= 1'b0;
                        done  <= 1'b1;
                    end else if (timer == '0) begin
                        // remaining<=1 also covers an impossible 0 so the count never wraps
                        if (remaining <= NW'(1)) begin
                            state <= S_DONE;
                            buzz  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            remaining <= remaining - NW'(1);
                            state     <= S_GAP;
                            timer     <= OFF_LOAD;
                            buzz      <= 1'b0;
                        end
                    end else begin
                        timer <= timer - CW'(1);
                    end
                end

                S_GAP: begin
                    if (stop) begin
                        state <= S_DONE;
                        buzz  <= 1'b0;
                        done  <= 1'b1;
                    end else if (timer == '0) begin
                        state <= S_ON;
                        timer <= ON_LOAD;
                        buzz  <= 1'b1;
                    end else begin
                        timer <= timer - CW'(1);
                    end
                end

                S_DONE: begin
                    // single-cycle pulse, then back to idle regardless of inputs
                    state <= S_IDLE;
                    buzz  <= 1'b0;
                    done  <= 1'b0;
                end

                default: begin
                    state <= S_IDLE;
                    buzz  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_beep_driver.sv
module tb_beep_driver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       a_start, b_start, stop;
    logic [3:0] beeps;
    logic       a_ready, a_busy, a_buzz, a_done;
    logic       b_ready, b_busy, b_buzz, b_done;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic buzz;
        logic done;
        logic ready;
        logic busy;
    } obs_t;

    obs_t exp_q[$];

    // Short pattern instance
    beep_driver #(.ON_CYC(3), .OFF_CYC(2), .CW(4), .NW(4)) u_a (
        .clk(clk), .rst_n(rst_n), .start(a_start), .beeps(beeps), .stop(stop),
        .ready(a_ready), .busy(a_busy), .buzz(a_buzz), .done(a_done)
    );

    // Full-range timer instance (phase length 2^CW)
    beep_driver #(.ON_CYC(16), .OFF_CYC(16), .CW(4), .NW(4)) u_b (
        .clk(clk), .rst_n(rst_n), .start(b_start), .beeps(beeps), .stop(stop),
        .ready(b_ready), .busy(b_busy), .buzz(b_buzz), .done(b_done)
    );

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    // Expected {buzz,done,ready,busy} in cycle k after acceptance in cycle 0.
    function automatic obs_t model(input int n, input int on, input int off,
                                   input int abort_s, input int k);
        int   t;
        int   p;
        logic b;
        obs_t r;
        t = (n == 0) ? 1 : n * on + (n - 1) * off + 1;
        p = on + off;
        if (abort_s > 0 && k > abort_s) begin
            if (k == abort_s + 1) r = 4'b0101;
            else                  r = 4'b0010;
        end else if (k > t) begin
            r = 4'b0010;
        end else if (k == t) begin
            r = 4'b0101;
        end else begin
            b = (((k - 1) / p) < n) && (((k - 1) % p) < on);
            r = {b, 3'b001};
        end
        return r;
    endfunction

    // Called at a negedge (cycle 0). Accepts a request, then compares each
    // following cycle against the scoreboard. Returns at the negedge of the
    // first ready cycle, so an immediate further call is a back-to-back start.
    task automatic run_pattern(input bit sel, input int n, input int abort_s,
                               input int busy_at, input string name);
        int   on, off, t, len;
        obs_t e, o;
        on  = sel ? 16 : 3;
        off = sel ? 16 : 2;
        t   = (n == 0) ? 1 : n * on + (n - 1) * off + 1;
        len = (abort_s > 0) ? abort_s + 2 : t + 1;
        for (int k = 1; k <= len; k++) exp_q.push_back(model(n, on, off, abort_s, k));
        if (sel) b_start = 1'b1; else a_start = 1'b1;
        beeps = n[3:0];
        stop  = 1'b0;
        for (int k = 1; k <= len; k++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            o = sel ? {b_buzz, b_done, b_ready, b_busy} : {a_buzz, a_done, a_ready, a_busy};
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL %s cycle %0d: buzz/done/ready/busy got %b expected %b", name, k, o, e);
            end
            a_start = !sel && (k == busy_at);
            b_start = sel && (k == busy_at);
            beeps   = (k == busy_at) ? 4'd5 : n[3:0];
            stop    = (k == abort_s);
        end
        a_start = 1'b0;
        b_start = 1'b0;
        stop    = 1'b0;
    endtask

    task automatic check_idle(input string name);
        checks++;
        if ({a_buzz, a_done, a_ready, a_busy} !== 4'b0010) begin
            errors++;
            $display("FAIL %s A: buzz/done/ready/busy got %b expected 0010", name,
                     {a_buzz, a_done, a_ready, a_busy});
        end
        checks++;
        if ({b_buzz, b_done, b_ready, b_busy} !== 4'b0010) begin
            errors++;
            $display("FAIL %s B: buzz/done/ready/busy got %b expected 0010", name,
                     {b_buzz, b_done, b_ready, b_busy});
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; a_start = 1'b0; b_start = 1'b0; stop = 1'b0; beeps = '0;
        repeat (3) @(negedge clk);
        check_idle("reset_held");
        rst_n = 1'b1;
        @(negedge clk);
        check_idle("reset_released");
    endtask

    task automatic test_basic();
        run_pattern(1'b0, 2, 0, 0, "two_beeps");
        @(negedge clk);
        run_pattern(1'b0, 1, 0, 0, "one_beep");
        @(negedge clk);
        run_pattern(1'b0, 15, 0, 0, "fifteen_beeps");
        @(negedge clk);
    endtask

    task automatic test_zero();
        run_pattern(1'b0, 0, 0, 0, "zero_beeps");
        @(negedge clk);
    endtask

    task automatic test_abort();
        run_pattern(1'b0, 3, 7, 0, "abort_in_beep");
        @(negedge clk);
        run_pattern(1'b0, 3, 4, 0, "abort_in_gap");
        @(negedge clk);
    endtask

    task automatic test_busy_start();
        run_pattern(1'b0, 2, 0, 4, "start_while_busy");
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        run_pattern(1'b0, 1, 0, 0, "b2b_first");
        run_pattern(1'b0, 2, 0, 0, "b2b_second");
        @(negedge clk);
    endtask

    task automatic test_stop_in_idle();
        a_start = 1'b1; stop = 1'b1; beeps = 4'd3;
        @(negedge clk);
        a_start = 1'b0; stop = 1'b0;
        check_idle("stop_vetoes_start_c1");
        @(negedge clk);
        check_idle("stop_vetoes_start_c2");
    endtask

    task automatic test_long();
        run_pattern(1'b1, 15, 0, 0, "full_range_timer");
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        a_start = 1'b1; beeps = 4'd3; stop = 1'b0;
        @(negedge clk);
        a_start = 1'b0;
        checks++;
        if (a_buzz !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_running: buzz got %b expected 1", a_buzz);
        end
        @(negedge clk);
        rst_n = 1'b0; a_start = 1'b1; stop = 1'b1;
        @(negedge clk);
        check_idle("reset_mid_in_reset");
        rst_n = 1'b1; a_start = 1'b0; stop = 1'b0;
        @(negedge clk);
        check_idle("reset_mid_released");
        run_pattern(1'b0, 2, 0, 0, "after_reset");
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero();
        test_abort();
        test_busy_start();
        test_back_to_back();
        test_stop_in_idle();
        test_long();
        test_reset_mid();
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
